// File: rtl/rtp_engine_pkg.sv
// rtp_engine_pkg: AXI response codes, timeout read data and FSM state types for the up_* bridge
package rtp_engine_pkg;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_DEAD;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_WAIT, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_RESP} r_state_t;
endpackage

// File: rtl/rtp_engine_up_ack_timer.sv
// rtp_engine_up_ack_timer: counts WAIT cycles, expired flags the last cycle an ack may still arrive
module rtp_engine_up_ack_timer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic up_clk,
  input  logic up_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam logic [9:0] LAST = 10'(TIMEOUT_CYCLES - 1);
  logic [9:0] cnt;
  always_ff @(posedge up_clk) begin
    if (up_rst || clear) cnt <= '0;
    else if (enable && !expired) cnt <= cnt + 10'd1;
  end
  assign expired = enable && cnt == LAST;
endmodule

// File: rtl/rtp_engine_up_axi.sv
// rtp_engine_up_axi: AXI4-Lite slave bridging to the word-addressed up_* register bus with ack timeout
module rtp_engine_up_axi
  import rtp_engine_pkg::*;
#(
  parameter int AXI_ADDRESS_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         up_clk,
  input  logic                         up_rst,
  input  logic                         s_axi_awvalid,
  input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_awaddr,
  output logic                         s_axi_awready,
  input  logic                         s_axi_wvalid,
  input  logic [31:0]                  s_axi_wdata,
  input  logic [3:0]                   s_axi_wstrb,
  output logic                         s_axi_wready,
  output logic                         s_axi_bvalid,
  output logic [1:0]                   s_axi_bresp,
  input  logic                         s_axi_bready,
  input  logic                         s_axi_arvalid,
  input  logic [AXI_ADDRESS_WIDTH-1:0] s_axi_araddr,
  output logic                         s_axi_arready,
  output logic                         s_axi_rvalid,
  output logic [31:0]                  s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  input  logic                         s_axi_rready,
  output logic                         up_wreq,
  output logic [13:0]                  up_waddr,
  output logic [31:0]                  up_wdata,
  input  logic                         up_wack,
  output logic                         up_rreq,
  output logic [13:0]                  up_raddr,
  input  logic [31:0]                  up_rdata,
  input  logic                         up_rack
);
  w_state_t w_state, w_next;
  r_state_t r_state, r_next;
  logic aw_got, w_got, aw_hs, w_hs, ar_hs, w_exp, r_exp, unused;
  // Byte lanes and address bits outside [15:2] carry no meaning on the up_* bus
  assign unused = ^{s_axi_wstrb, s_axi_awaddr, s_axi_araddr};
  assign s_axi_awready = !up_rst && w_state == W_IDLE && !aw_got;
  assign s_axi_wready = !up_rst && w_state == W_IDLE && !w_got;
  assign s_axi_bvalid = w_state == W_RESP;
  assign up_wreq = w_state == W_REQ;
  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs = s_axi_wvalid && s_axi_wready;
  assign s_axi_arready = !up_rst && r_state == R_IDLE;
  assign s_axi_rvalid = r_state == R_RESP;
  assign up_rreq = r_state == R_REQ;
  assign ar_hs = s_axi_arvalid && s_axi_arready;
  always_comb begin
    w_next = w_state;
    w_next = w_state == W_IDLE ? ((aw_got || aw_hs) && (w_got || w_hs) ? W_REQ : W_IDLE) :
             w_state == W_REQ  ? W_WAIT :
             w_state == W_WAIT ? (up_wack || w_exp ? W_RESP : W_WAIT) :
             (s_axi_bready ? W_IDLE : W_RESP);
  end
  always_comb begin
    r_next = r_state;
    r_next = r_state == R_IDLE ? (ar_hs ? R_REQ : R_IDLE) :
             r_state == R_REQ  ? R_WAIT :
             r_state == R_WAIT ? (up_rack || r_exp ? R_RESP : R_WAIT) :
             (s_axi_rready ? R_IDLE : R_RESP);
  end
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      w_state <= W_IDLE;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      up_waddr <= '0;
      up_wdata <= '0;
      s_axi_bresp <= AXI_RESP_OKAY;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        aw_got <= 1'b1;
        up_waddr <= s_axi_awaddr[15:2];
      end
      if (w_hs) begin
        w_got <= 1'b1;
        up_wdata <= s_axi_wdata;
      end
      if (w_state == W_REQ) begin
        aw_got <= 1'b0;
        w_got <= 1'b0;
      end
      if (w_state == W_WAIT && (up_wack || w_exp)) s_axi_bresp <= up_wack ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
    end
  end
  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      r_state <= R_IDLE;
      up_raddr <= '0;
      s_axi_rdata <= '0;
      s_axi_rresp <= AXI_RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) up_raddr <= s_axi_araddr[15:2];
      if (r_state == R_WAIT && (up_rack || r_exp)) begin
        s_axi_rdata <= up_rack ? up_rdata : TIMEOUT_RDATA;
        s_axi_rresp <= up_rack ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
      end
    end
  end
  rtp_engine_up_ack_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_w_timer (
    .up_clk (up_clk),
    .up_rst (up_rst),
    .clear  (w_state == W_REQ),
    .enable (w_state == W_WAIT),
    .expired(w_exp)
  );
  rtp_engine_up_ack_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_r_timer (
    .up_clk (up_clk),
    .up_rst (up_rst),
    .clear  (r_state == R_REQ),
    .enable (r_state == R_WAIT),
    .expired(r_exp)
  );
endmodule

// File: tb/tb_rtp_engine_up_axi.sv
// tb_rtp_engine_up_axi: randomized bench against a regmap/responder model with per-cycle output checks
module tb_rtp_engine_up_axi;
  localparam int T = 16;
  logic up_clk = 1'b0, up_rst = 1'b1;
  logic s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
  logic s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
  logic [15:0] s_axi_awaddr = '0, s_axi_araddr = '0;
  logic [31:0] s_axi_wdata = '0;
  logic [3:0] s_axi_wstrb = '0;
  logic s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
  logic [1:0] s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata, up_wdata, up_rdata;
  logic up_wreq, up_rreq, up_wack, up_rack;
  logic [13:0] up_waddr, up_raddr;
  rtp_engine_up_axi #(.AXI_ADDRESS_WIDTH(16), .TIMEOUT_CYCLES(T)) dut (
    .up_clk(up_clk), .up_rst(up_rst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awready(s_axi_awready),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wready(s_axi_wready), .s_axi_bvalid(s_axi_bvalid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bready(s_axi_bready), .s_axi_arvalid(s_axi_arvalid), .s_axi_araddr(s_axi_araddr),
    .s_axi_arready(s_axi_arready), .s_axi_rvalid(s_axi_rvalid), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp), .s_axi_rready(s_axi_rready),
    .up_wreq(up_wreq), .up_waddr(up_waddr), .up_wdata(up_wdata), .up_wack(up_wack),
    .up_rreq(up_rreq), .up_raddr(up_raddr), .up_rdata(up_rdata), .up_rack(up_rack)
  );
  always #5 up_clk = ~up_clk;
  int total = 0, bad = 0, cyc = 0;
  always @(posedge up_clk) cyc <= cyc + 1;
  logic [31:0] mem [64];
  int w_dly = 1, r_dly = 1;
  bit w_busy = 0, r_busy = 0, b_pending = 0, r_pending = 0;
  logic [5:0] ridx;
  logic [13:0] exp_waddr, exp_raddr, last_waddr;
  logic [31:0] exp_wdata, exp_rdata, last_rdata;
  logic [1:0] exp_bresp, exp_rresp, last_bresp;
  int wreq_cnt = 0, rreq_cnt = 0, wreq_cyc = -1, rreq_cyc = -1, r_lat = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Regmap model: stores on request, acks after a programmable delay (0 = never)
  initial begin
    up_wack = 1'b0;
    forever begin
      @(negedge up_clk);
      if (up_wreq && !up_rst) begin
        mem[up_waddr[5:0]] = up_wdata;
        if (w_dly > 0) begin
          w_busy = 1;
          repeat (w_dly) @(posedge up_clk);
          #1 up_wack = 1'b1;
          @(posedge up_clk);
          #1 up_wack = 1'b0;
          w_busy = 0;
        end
      end
    end
  end
  initial begin
    up_rack = 1'b0;
    up_rdata = '0;
    forever begin
      @(negedge up_clk);
      if (!up_rack) up_rdata = $urandom;
      if (up_rreq && !up_rst && r_dly > 0) begin
        r_busy = 1;
        ridx = up_raddr[5:0];
        repeat (r_dly) @(posedge up_clk);
        #1 up_rack = 1'b1;
        up_rdata = mem[ridx];
        @(posedge up_clk);
        #1 up_rack = 1'b0;
        r_busy = 0;
      end
    end
  end

  // Per-cycle compare of everything the DUT presents against the model's expectations
  always @(negedge up_clk) begin
    if (!up_rst) begin
      if (up_wreq) begin
        wreq_cnt++;
        wreq_cyc = cyc;
        last_waddr = up_waddr;
        chk("up_waddr", 32'(up_waddr), 32'(exp_waddr));
        chk("up_wdata", up_wdata, exp_wdata);
      end
      if (up_rreq) begin
        rreq_cnt++;
        rreq_cyc = cyc;
        chk("up_raddr", 32'(up_raddr), 32'(exp_raddr));
      end
      if (s_axi_bvalid) begin
        last_bresp = s_axi_bresp;
        chk("bvalid_expected", 32'(b_pending), 32'd1);
        chk("bresp", 32'(s_axi_bresp), 32'(exp_bresp));
      end
      if (s_axi_rvalid) begin
        last_rdata = s_axi_rdata;
        chk("rvalid_expected", 32'(r_pending), 32'd1);
        chk("rdata", s_axi_rdata, exp_rdata);
        chk("rresp", 32'(s_axi_rresp), 32'(exp_rresp));
      end
    end
  end

  task automatic send_w(input logic [15:0] a, input logic [31:0] d, input int aw_off, input int w_off,
                        output int n);
    int ca = -1, cw = -1;
    exp_waddr = a[15:2];
    exp_wdata = d;
    fork
      begin
        repeat (aw_off) begin @(posedge up_clk); #1; end
        s_axi_awvalid = 1'b1;
        s_axi_awaddr = a;
        for (int i = 0; i < 50 && ca < 0; i++) begin
          @(negedge up_clk);
          if (s_axi_awready) ca = cyc;
          else begin @(posedge up_clk); #1; end
        end
        @(posedge up_clk);
        #1 s_axi_awvalid = 1'b0;
      end
      begin
        repeat (w_off) begin @(posedge up_clk); #1; end
        s_axi_wvalid = 1'b1;
        s_axi_wdata = d;
        s_axi_wstrb = 4'($urandom);
        for (int i = 0; i < 50 && cw < 0; i++) begin
          @(negedge up_clk);
          if (s_axi_wready) cw = cyc;
          else begin @(posedge up_clk); #1; end
        end
        @(posedge up_clk);
        #1 s_axi_wvalid = 1'b0;
      end
    join
    chk("aw_w_accepted", 32'(ca >= 0 && cw >= 0), 32'd1);
    n = ca > cw ? ca : cw;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input int dly, input int aw_off,
                          input int w_off, input int hold);
    bit ok = dly >= 1 && dly <= T;
    int n, bc = -1, c0 = wreq_cnt;
    w_dly = dly;
    exp_bresp = ok ? 2'b00 : 2'b10;
    b_pending = 1;
    send_w(a, d, aw_off, w_off, n);
    for (int i = 0; i < 200 && bc < 0; i++) begin
      @(negedge up_clk);
      if (s_axi_bvalid) bc = cyc;
    end
    chk("b_latency", 32'(bc - n), 32'(ok ? dly + 2 : T + 2));
    chk("wreq_latency", 32'(wreq_cyc - n), 32'd1);
    chk("wreq_count", 32'(wreq_cnt - c0), 32'd1);
    repeat (hold) begin @(posedge up_clk); #1; end
    s_axi_bready = 1'b1;
    @(posedge up_clk);
    #1 s_axi_bready = 1'b0;
    b_pending = 0;
    for (int i = 0; i < 100 && w_busy; i++) begin @(posedge up_clk); #1; end
  endtask

  task automatic do_read(input logic [15:0] a, input int dly, input int hold);
    bit ok = dly >= 1 && dly <= T;
    int n = -1, rc = -1, c0 = rreq_cnt;
    r_dly = dly;
    exp_raddr = a[15:2];
    exp_rdata = ok ? mem[a[7:2]] : 32'hDEAD_DEAD;
    exp_rresp = ok ? 2'b00 : 2'b10;
    r_pending = 1;
    s_axi_arvalid = 1'b1;
    s_axi_araddr = a;
    for (int i = 0; i < 50 && n < 0; i++) begin
      @(negedge up_clk);
      if (s_axi_arready) n = cyc;
      else begin @(posedge up_clk); #1; end
    end
    @(posedge up_clk);
    #1 s_axi_arvalid = 1'b0;
    for (int i = 0; i < 200 && rc < 0; i++) begin
      @(negedge up_clk);
      if (s_axi_rvalid) rc = cyc;
    end
    r_lat = rc - n;
    chk("ar_accepted", 32'(n >= 0), 32'd1);
    chk("r_latency", 32'(r_lat), 32'(ok ? dly + 2 : T + 2));
    chk("rreq_latency", 32'(rreq_cyc - n), 32'd1);
    chk("rreq_count", 32'(rreq_cnt - c0), 32'd1);
    repeat (hold) begin @(posedge up_clk); #1; end
    s_axi_rready = 1'b1;
    @(posedge up_clk);
    #1 s_axi_rready = 1'b0;
    r_pending = 0;
    for (int i = 0; i < 100 && r_busy; i++) begin @(posedge up_clk); #1; end
  endtask

  function automatic int pick_dly();
    int k = $urandom_range(0, 9);
    return k == 0 ? 0 : k == 1 ? T + 1 + $urandom_range(0, 2) : $urandom_range(1, T);
  endfunction

  initial begin
    int n, seen;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    mem[2] = 32'h0000_0456;
    repeat (3) @(posedge up_clk);
    @(negedge up_clk);
    chk("rst_awready", 32'(s_axi_awready), 32'd0);
    chk("rst_wready", 32'(s_axi_wready), 32'd0);
    chk("rst_arready", 32'(s_axi_arready), 32'd0);
    chk("rst_valids", {28'd0, s_axi_bvalid, s_axi_rvalid, up_wreq, up_rreq}, 32'd0);
    chk("rst_resp", {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);
    chk("rst_rdata", s_axi_rdata, 32'd0);
    chk("rst_up_addr", {4'd0, up_waddr, up_raddr}, 32'd0);
    chk("rst_wdata", up_wdata, 32'd0);
    @(posedge up_clk);
    #1 up_rst = 1'b0;
    @(negedge up_clk);
    chk("post_rst_ready", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);
    @(posedge up_clk);
    #1;
    do_write(16'h0004, 32'h0000_0123, 1, 0, 0, 0);
    chk("lit_waddr_1", 32'(last_waddr), 32'd1);
    chk("lit_bresp_ok", 32'(last_bresp), 32'd0);
    do_read(16'h0004, 1, 0);
    chk("lit_readback_123", last_rdata, 32'h0000_0123);
    do_write(16'h0014, 32'h0000_0001, 1, 5, 0, 0);
    chk("lit_waddr_5", 32'(last_waddr), 32'd5);
    do_read(16'h0008, 1, 4);
    chk("lit_rdata_456", last_rdata, 32'h0000_0456);
    do_read(16'h000C, 0, 0);
    chk("lit_timeout_rdata", last_rdata, 32'hDEAD_DEAD);
    chk("lit_timeout_lat", 32'(r_lat), 32'd18);
    do_write(16'h0018, 32'h0000_0aaa, 0, 0, 0, 0);
    chk("lit_bresp_slverr", 32'(last_bresp), 32'd2);
    do_write(16'h001C, 32'h0000_0bbb, T + 1, 0, 0, 2);
    do_read(16'h0010, T + 2, 0);
    do_write(16'h0020, 32'h0000_0ccc, 1, 0, 0, 0);
    // reset while the write is stalled waiting for an ack that never comes
    w_dly = 0;
    b_pending = 1;
    send_w(16'h0024, 32'h0000_0ddd, 0, 0, n);
    repeat (3) begin @(posedge up_clk); #1; end
    up_rst = 1'b1;
    b_pending = 0;
    @(posedge up_clk);
    #1 up_rst = 1'b0;
    @(negedge up_clk);
    chk("after_rst_awready", 32'(s_axi_awready), 32'd1);
    chk("after_rst_wready", 32'(s_axi_wready), 32'd1);
    seen = 0;
    repeat (T + 4) begin
      if (s_axi_bvalid) seen++;
      @(negedge up_clk);
    end
    chk("dropped_bvalid", 32'(seen), 32'd0);
    @(posedge up_clk);
    #1;
    do_write(16'h0028, 32'h0000_0eee, 2, 0, 0, 0);
    fork
      do_write(16'h0004, 32'h0000_0777, 1, 0, 0, 0);
      do_read(16'h0000, 1, 0);
    join
    chk("concurrent_req_cycle", 32'(wreq_cyc), 32'(rreq_cyc));
    for (int t = 0; t < 30; t++) begin
      int mode = $urandom_range(0, 2);
      logic [15:0] wa = 16'($urandom), ra = 16'($urandom);
      if (ra[7:2] == wa[7:2]) ra[2] = ~ra[2];
      if (mode == 0) do_write(wa, $urandom, pick_dly(), $urandom_range(0, 3), $urandom_range(0, 3),
                              $urandom_range(0, 3));
      else if (mode == 1) do_read(ra, pick_dly(), $urandom_range(0, 3));
      else fork
        do_write(wa, $urandom, pick_dly(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        do_read(ra, pick_dly(), $urandom_range(0, 3));
      join
    end
    repeat (3) @(posedge up_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/rtp_engine_up_axi.md
Name: rtp_engine_up_axi

Overview:
AXI4-Lite slave that initiates transactions on the rtp_engine up_* register bus (up_wreq/up_waddr/up_wdata -> up_wack, up_rreq/up_raddr -> up_rdata/up_rack). It sits between the processor interconnect and rtp_engine_regmap.
- Converts byte-addressed AXI accesses to 14-bit word-addressed up_* requests.
- Waits for the responder's ack and returns the AXI response.
- Returns an error response if no ack arrives within a bounded time.
- Read and write paths are fully independent.

Parameters:
AXI_ADDRESS_WIDTH, 16, AXI address width; must be >= 16; bits above [15] are ignored.
TIMEOUT_CYCLES, 255, number of WAIT cycles without ack before an error response; range 1..1023.

Ports:
up_clk  in  1  single clock for AXI and up_* sides.
up_rst  in  1  synchronous, active-high reset.
s_axi_awvalid  in  1  write address valid.
s_axi_awaddr  in  AXI_ADDRESS_WIDTH  write byte address.
s_axi_awready  out  1  write address ready.
s_axi_wvalid  in  1  write data valid.
s_axi_wdata  in  32  write data.
s_axi_wstrb  in  4  byte strobes; ignored, every write is full-word.
s_axi_wready  out  1  write data ready.
s_axi_bvalid  out  1  write response valid.
s_axi_bresp  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
s_axi_bready  in  1  write response ready.
s_axi_arvalid  in  1  read address valid.
s_axi_araddr  in  AXI_ADDRESS_WIDTH  read byte address.
s_axi_arready  out  1  read address ready.
s_axi_rvalid  out  1  read data valid.
s_axi_rdata  out  32  read data.
s_axi_rresp  out  2  read response.
s_axi_rready  in  1  read data ready.
up_wreq  out  1  one-cycle write request pulse.
up_waddr  out  14  word address, equal to awaddr[15:2].
up_wdata  out  32  write data.
up_wack  in  1  write acknowledge.
up_rreq  out  1  one-cycle read request pulse.
up_raddr  out  14  word address, equal to araddr[15:2].
up_rdata  in  32  read data, valid when up_rack=1.
up_rack  in  1  read acknowledge.

Behaviour:
- Reset (synchronous, up_rst=1):
  - both FSMs go to IDLE;
  - all valid, ready and req outputs go to 0;
  - bresp, rresp, rdata, up_waddr, up_raddr and up_wdata go to 0.
  - A transaction in flight at reset is dropped; no response is issued for it.
- Write FSM, states W_IDLE, W_REQ, W_WAIT, W_RESP:
  - W_IDLE: awready=1 while the address is not yet captured; wready=1 while the data is not yet captured. AW and W may arrive in either order or in the same cycle; each is latched on its own handshake.
  - When both are latched, go to W_REQ. up_wreq=1 for exactly one cycle there, with up_waddr and up_wdata stable.
  - W_REQ -> W_WAIT unconditionally. In W_WAIT the timer clears on entry and increments each cycle.
  - up_wack=1 in W_WAIT -> W_RESP with bresp=OKAY.
  - Timer reaching TIMEOUT_CYCLES with no ack -> W_RESP with bresp=SLVERR.
  - W_RESP: bvalid=1 until bready=1, then W_IDLE. awready and wready stay 0 outside W_IDLE.
- Read FSM, states R_IDLE, R_REQ, R_WAIT, R_RESP:
  - R_IDLE: arready=1; the address is latched on handshake -> R_REQ.
  - R_REQ: up_rreq=1 for one cycle -> R_WAIT, timer as for writes.
  - up_rack=1 -> R_RESP; rdata latched from up_rdata, rresp=OKAY.
  - Timeout -> R_RESP with rdata=32'hDEAD_DEAD, rresp=SLVERR.
  - R_RESP: rvalid=1 until rready=1; rdata and rresp stay stable while rvalid=1.
- Acks are sampled only in *_WAIT. Acks in IDLE, REQ or RESP are ignored, including a late ack that arrives after a timeout.
- Latency with a 1-cycle-ack responder:
  - write: AW and W handshake in cycle N -> up_wreq N+1 -> up_wack N+2 -> bvalid N+3;
  - read: AR in cycle N -> up_rreq N+1 -> rack N+2 -> rvalid N+3.
- A simultaneous read and write proceed concurrently on independent paths.
- At most one outstanding transaction per direction.

Decomposition:
- Package rtp_engine_pkg holds:
  - AXI_RESP_OKAY = 2'b00 and AXI_RESP_SLVERR = 2'b10;
  - TIMEOUT_RDATA = 32'hDEAD_DEAD;
  - typedef enums for the write and read FSM states.
- Sub-module rtp_engine_up_ack_timer (ports: clear, enable, expired), parameterised by TIMEOUT_CYCLES; instantiated once per direction.

Test Plan:
- Write 0x00000123 to byte address 0x4 with AW and W in the same cycle, against a regmap model -> up_wreq pulse at N+1 with up_waddr=1; bvalid at N+3 with bresp=OKAY; a readback of address 0x4 returns rdata=0x123.
- W arrives 5 cycles before AW at byte address 0x14, data 0x1 -> no up_wreq until AW is latched; up_waddr=5; exactly one up_wreq pulse.
- Read of byte address 0x8 while rready is held low for 4 cycles -> rvalid stays 1 with stable rdata=0x00000456 (the preloaded value) until rready=1.
- Responder never acks, TIMEOUT_CYCLES=16 -> rvalid after 16 WAIT cycles with rdata=0xDEADDEAD and rresp=SLVERR; a write gets bresp=SLVERR; a late ack has no effect.
- Reset asserted for 1 cycle while the write FSM is in W_WAIT -> bvalid never asserts; awready=1 and wready=1 the cycle after reset; the next write completes normally.
- Concurrent read of address 0x0 and write to address 0x4 in the same cycle -> both up_rreq and up_wreq pulse at N+1; both responses are OKAY.
